// File: rtl/game_pkg.sv
// Shared types, board constants and tile helpers for the turn sequencer.
package game_pkg;

  localparam int unsigned NUM_TILES  = 10;
  localparam int unsigned TILE_X0    = 20;
  localparam int unsigned TILE_PITCH = 60;
  localparam int unsigned TILE_W     = 4;
  localparam int unsigned SUM_W      = TILE_W + 1;
  localparam int unsigned X_W        = 10;
  localparam int unsigned DICE_W     = 3;

  // One bit per tile index; set bits are question-box tiles (2, 4, 6, 8).
  localparam logic [15:0] BONUS_TILE_MASK = 16'h0154;

  typedef enum logic [2:0] {
    WAIT_DICE,
    MOVE,
    WAIT_DONE,
    BONUS,
    FINISH
  } turn_state_t;

  // Screen x coordinate of a tile centre.
  function automatic logic [X_W-1:0] tile_to_x(input logic [TILE_W-1:0] tile);
    return X_W'(TILE_X0) + X_W'(tile) * X_W'(TILE_PITCH);
  endfunction

  function automatic logic is_bonus_tile(input logic [TILE_W-1:0] tile);
    return BONUS_TILE_MASK[tile];
  endfunction

  // Advance a tile index, stopping on the finish tile instead of overshooting.
  function automatic logic [TILE_W-1:0] clamp_add(input logic [TILE_W-1:0] tile,
                                                  input logic [DICE_W-1:0] inc);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(tile) + SUM_W'(inc);
    if (sum > SUM_W'(NUM_TILES - 1)) sum = SUM_W'(NUM_TILES - 1);
    return sum[TILE_W-1:0];
  endfunction

endpackage

// File: rtl/turn_watchdog.sv
// Cycle counter bounding how long a turn may wait for the renderer.
module turn_watchdog #(
  parameter int unsigned TURN_TIMEOUT = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_c
);

  localparam int unsigned CNT_W = (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;

  logic [CNT_W-1:0] cnt_q;

  // Count while enabled; clear wins so every wait starts from zero.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expire_c = en_i && (cnt_q == CNT_W'(TURN_TIMEOUT - 1));

endmodule

// File: rtl/game_turn_sequencer.sv
// Two-player board game turn controller feeding the UI game renderer.
module game_turn_sequencer
  import game_pkg::*;
#(
  parameter int unsigned TURN_TIMEOUT = 50_000_000,
  parameter bit          BONUS_EN     = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dice_valid,
  input  logic [DICE_W-1:0] dice_value,
  output logic              dice_ready,
  input  logic              game_restart,
  input  logic              turn_done,
  output logic [X_W-1:0]    player1_pos_x,
  output logic [X_W-1:0]    player2_pos_x,
  output logic              pos_valid,
  output logic              active_player,
  output logic              winner_valid,
  output logic              winner_id,
  output logic              timeout_flag
);

  turn_state_t       state_q;
  logic [TILE_W-1:0] p1_tile_q, p2_tile_q;
  logic [X_W-1:0]    p1_x_q, p2_x_q;
  logic              active_q, bonus_taken_q, pos_valid_q, dice_ready_q;
  logic              winner_valid_q, winner_id_q, timeout_q;

  logic [TILE_W-1:0] cur_tile_c, upd_tile_c;
  logic              dice_legal_c, wd_en_c, wd_expire_c, wd_clr_c, wait_exit_c;

  // Active player's tile and the tile it moves to on a roll or a bonus step.
  always_comb begin
    cur_tile_c   = active_q ? p2_tile_q : p1_tile_q;
    dice_legal_c = (dice_value != DICE_W'(0)) && (dice_value != DICE_W'(7));
    upd_tile_c   = (state_q == WAIT_DICE) ? clamp_add(cur_tile_c, dice_value)
                                          : clamp_add(cur_tile_c, DICE_W'(1));
    wd_en_c      = (state_q == WAIT_DONE);
    wait_exit_c  = wd_en_c && (turn_done || wd_expire_c);
    wd_clr_c     = !wd_en_c || wait_exit_c || game_restart;
  end

  turn_watchdog #(
    .TURN_TIMEOUT(TURN_TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (wd_clr_c),
    .en_i    (wd_en_c),
    .expire_c(wd_expire_c)
  );

  // Turn FSM; position registers move on the edge entering MOVE/BONUS so the
  // pulse and the new coordinate are visible together during that state.
  always_ff @(posedge clk) begin
    if (rst || game_restart) begin
      state_q        <= WAIT_DICE;
      p1_tile_q      <= '0;
      p2_tile_q      <= '0;
      p1_x_q         <= X_W'(TILE_X0);
      p2_x_q         <= X_W'(TILE_X0);
      active_q       <= 1'b0;
      bonus_taken_q  <= 1'b0;
      pos_valid_q    <= 1'b0;
      dice_ready_q   <= 1'b1;
      winner_valid_q <= 1'b0;
      winner_id_q    <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      pos_valid_q <= 1'b0;
      case (state_q)
        WAIT_DICE: begin
          if (dice_valid && dice_legal_c) begin
            state_q      <= MOVE;
            dice_ready_q <= 1'b0;
            pos_valid_q  <= 1'b1;
            if (active_q) begin
              p2_tile_q <= upd_tile_c;
              p2_x_q    <= tile_to_x(upd_tile_c);
            end else begin
              p1_tile_q <= upd_tile_c;
              p1_x_q    <= tile_to_x(upd_tile_c);
            end
          end
        end
        MOVE: state_q <= WAIT_DONE;
        WAIT_DONE: begin
          if (wait_exit_c) begin
            if (wd_expire_c) timeout_q <= 1'b1;
            if (cur_tile_c == TILE_W'(NUM_TILES - 1)) begin
              state_q        <= FINISH;
              winner_valid_q <= 1'b1;
              winner_id_q    <= active_q;
            end else if (BONUS_EN && is_bonus_tile(cur_tile_c) && !bonus_taken_q) begin
              state_q       <= BONUS;
              bonus_taken_q <= 1'b1;
              pos_valid_q   <= 1'b1;
              if (active_q) begin
                p2_tile_q <= upd_tile_c;
                p2_x_q    <= tile_to_x(upd_tile_c);
              end else begin
                p1_tile_q <= upd_tile_c;
                p1_x_q    <= tile_to_x(upd_tile_c);
              end
            end else begin
              state_q       <= WAIT_DICE;
              active_q      <= ~active_q;
              bonus_taken_q <= 1'b0;
              dice_ready_q  <= 1'b1;
            end
          end
        end
        BONUS:   state_q <= WAIT_DONE;
        FINISH:  state_q <= FINISH;
        default: state_q <= WAIT_DICE;
      endcase
    end
  end

  assign player1_pos_x = p1_x_q;
  assign player2_pos_x = p2_x_q;
  assign pos_valid     = pos_valid_q;
  assign active_player = active_q;
  assign dice_ready    = dice_ready_q;
  assign winner_valid  = winner_valid_q;
  assign winner_id     = winner_id_q;
  assign timeout_flag  = timeout_q;

endmodule

// File: doc/game_turn_sequencer.md
Name: game_turn_sequencer

Overview:
Turn-based game controller that drives the UI game renderer's game-logic interface. It accepts dice results, advances the active player's tile index, and publishes target x coordinates with a pos_valid pulse. It waits for the renderer's turn_done, applies question-box bonus moves and detects the winner. It sits between the dice recognition path (camera/dice decoder) and UI_Game_Renderer.

Parameters:
NUM_TILES, 10, tiles 0..NUM_TILES-1; the last tile is the finish
TILE_X0, 20, x coordinate of tile 0
TILE_PITCH, 60, x distance between tiles (tile n x = TILE_X0 + n*TILE_PITCH)
TURN_TIMEOUT, 50_000_000, cycles to wait for turn_done before forcing progress
BONUS_EN, 1, 1 = landing on tiles 2/4/6/8 grants +1 tile bonus move

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
dice_valid  in  1  dice result strobe (1 cycle)
dice_value  in  3  dice face; only 1..6 are legal
dice_ready  out  1  high while a dice result is accepted (WAIT_DICE)
game_restart  in  1  pulse that returns the game to its start state
turn_done  in  1  renderer animation complete (1 cycle pulse)
player1_pos_x  out  10  player 1 target x
player2_pos_x  out  10  player 2 target x
pos_valid  out  1  position update pulse (1 cycle)
active_player  out  1  0 = Player1, 1 = Player2
winner_valid  out  1  level; high once a player reaches the finish
winner_id  out  1  winning player, valid while winner_valid
timeout_flag  out  1  sticky; set if any turn_done wait timed out

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high. game_restart has the same effect as rst, one cycle later, from any state.
- Reset values: state=WAIT_DICE; tiles p1=p2=0; player1_pos_x=player2_pos_x=TILE_X0; pos_valid=0; active_player=0; winner_valid=0; winner_id=0; dice_ready=1; timeout_flag=0; watchdog=0.
- States: WAIT_DICE, MOVE, WAIT_DONE, BONUS, FINISH.
- WAIT_DICE: dice_ready=1.
  - dice_valid with dice_value in 1..6 → MOVE.
  - Illegal values (0 or 7) are ignored; the state stays WAIT_DICE.
- MOVE (1 cycle):
  - new_tile = min(tile + dice_value, NUM_TILES-1), so there is no overshoot past the finish.
  - The active player's pos_x register updates and pos_valid=1 in the same cycle. Latency from accepting dice to pos_valid is 1 cycle.
  - The inactive player's pos_x is unchanged. Next state is WAIT_DONE.
- WAIT_DONE:
  - turn_done is sampled only in this state; a turn_done coinciding with the MOVE cycle is ignored.
  - The watchdog counts up. Either turn_done or watchdog == TURN_TIMEOUT-1 ends the wait; a timeout also sets timeout_flag. The watchdog clears on exit.
  - On exit, evaluated in this order:
    - If the tile equals NUM_TILES-1: go to FINISH.
    - Else if BONUS_EN, the tile is in {2,4,6,8}, and no bonus has been taken this turn: go to BONUS.
    - Else: toggle active_player and go to WAIT_DICE.
- BONUS (1 cycle):
  - tile += 1, clamped; pos_x updates; pos_valid=1; a bonus_taken flag is set; next state is WAIT_DONE.
  - At most one bonus per turn, so landing on tile 3 from a bonus cannot chain.
  - The bonus_taken flag clears when active_player toggles.
- FINISH:
  - winner_valid=1, winner_id=active_player; dice_ready=0.
  - dice_valid and turn_done are ignored. The block stays here until rst or game_restart.
- Arithmetic: the tile index is 4 bits. pos_x = TILE_X0 + tile*TILE_PITCH, computed on 10 bits and registered (at most 20+9*60=560 < 640).
- Simultaneous events: rst or game_restart beats every other input. dice_valid outside WAIT_DICE is dropped and not queued.
- Reset mid-move: pos_valid is deasserted the next cycle and positions return to TILE_X0. No pos_valid pulse is issued for the reset positions.

Decomposition:
- game_pkg holds:
  - the state enum (turn_state_t);
  - tile constants (NUM_TILES, TILE_X0, TILE_PITCH, the bonus tile list);
  - function tile_to_x(tile) returning logic [9:0];
  - function is_bonus_tile(tile).
- One sub-module is natural: turn_watchdog (counter with clear, enable and expire outputs, parameter TURN_TIMEOUT).

Test Plan:
1. Reset, then P1 dice_valid value=3 → next cycle pos_valid=1, player1_pos_x=200, player2_pos_x=20; after turn_done, active_player=1.
2. P1 rolls 2 (BONUS_EN=1) → pos_valid with x=140. turn_done → second pos_valid with x=200. turn_done → active_player toggles; exactly 2 pulses in total.
3. P2 at tile 7 rolls 5 → player2_pos_x=560 (clamped). turn_done → winner_valid=1, winner_id=1. A later dice_valid produces no pos_valid.
4. dice_value=0 and dice_value=7 in WAIT_DICE → no pos_valid, state unchanged. dice_valid during WAIT_DONE is dropped.
5. TURN_TIMEOUT=16, no turn_done → after 16 cycles in WAIT_DONE, timeout_flag=1 and active_player toggles.
6. game_restart asserted in WAIT_DONE with P1 at x=200 → next cycle both x=20, active_player=0, winner_valid=0, dice_ready=1.
